// File: rtl/syncfifo_pkg.sv
// syncfifo_pkg: read-mode encodings shared by the FIFO and its users
package syncfifo_pkg;
    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/syncfifo_ram.sv
// syncfifo_ram: WIDTH x 2^DEPTH simple dual-port storage, registered read port, no reset
// ports: clk; we/wa/wd write port; re/ra read enable/address; rq registered read data
module syncfifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [DEPTH-1:0] ra,
    output logic [WIDTH-1:0] rq
);
    logic [WIDTH-1:0] mem [2**DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rq <= mem[ra];
    end
endmodule

// File: rtl/syncfifo_prog.sv
// syncfifo_prog: synchronous FIFO with programmable almost-full/almost-empty and sticky error flags
// ports: clk; rst async active-low; wd/we write; re read, rd read data; ful/aful/emp/aemp status;
//        cnt word count; afull_th/aemp_th thresholds; ovf/udf sticky errors, err_clr clears them
module syncfifo_prog
    import syncfifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    parameter int FWFT  = FIFO_MODE_REG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wd,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] rd,
    output logic             ful,
    output logic             aful,
    output logic             emp,
    output logic             aemp,
    output logic [DEPTH:0]   cnt,
    input  logic [DEPTH:0]   afull_th,
    input  logic [DEPTH:0]   aemp_th,
    output logic             ovf,
    output logic             udf,
    input  logic             err_clr
);
    localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};
    localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);
    logic [DEPTH-1:0] wptr, rptr, rptr_nx;
    logic [DEPTH:0]   cnt_nx;
    logic             wr_ok, rd_ok, rd_v, byp_v;
    logic [WIDTH-1:0] byp_q, ram_q;
    assign wr_ok   = we & ~ful;
    assign rd_ok   = re & ~emp;
    assign rptr_nx = rptr + DEPTH'(rd_ok);
    assign cnt_nx  = cnt + (DEPTH+1)'(wr_ok) - (DEPTH+1)'(rd_ok);
    // FWFT prefetches the next head every edge; a word written into the head slot
    // on that same edge is not yet visible in the RAM, so it is forwarded from byp_q.
    // rd_v keeps rd at zero until the first word has been presented since reset.
    assign rd = !rd_v ? '0 : (IS_FWFT && byp_v) ? byp_q : ram_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ful   <= 1'b0;
            emp   <= 1'b1;
            aful  <= 1'b0;
            aemp  <= 1'b1;
            ovf   <= 1'b0;
            udf   <= 1'b0;
            rd_v  <= 1'b0;
            byp_v <= 1'b0;
        end else begin
            wptr  <= wptr + DEPTH'(wr_ok);
            rptr  <= rptr_nx;
            cnt   <= cnt_nx;
            ful   <= cnt_nx == CAP;
            emp   <= cnt_nx == '0;
            aful  <= cnt_nx >= afull_th;
            aemp  <= cnt_nx <= aemp_th;
            ovf   <= (we & ful) | (ovf & ~err_clr);
            udf   <= (re & emp) | (udf & ~err_clr);
            rd_v  <= rd_v | (IS_FWFT ? wr_ok : rd_ok);
            byp_v <= wr_ok & (wptr == rptr_nx);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) byp_q <= wd;
    end
    syncfifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk(clk),
        .we (wr_ok),
        .wa (wptr),
        .wd (wd),
        .re (IS_FWFT ? 1'b1 : rd_ok),
        .ra (IS_FWFT ? rptr_nx : rptr),
        .rq (ram_q)
    );
endmodule
